// File: rtl/bsg_nasti_req_serializer_pkg.sv
// Shared tags, arbitration modes and state types for the NASTI request serializer.
// Packet widths follow the module parameters, so the packet structs live in the top module.
package bsg_nasti_req_serializer_pkg;

    localparam logic BSG_NASTI_SER_ADDR = 1'b0;
    localparam logic BSG_NASTI_SER_DATA = 1'b1;

    localparam int ARB_ROUND_ROBIN = 0;
    localparam int ARB_WRITE_PRIO  = 1;
    localparam int ARB_READ_PRIO   = 2;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WDATA = 1'b1
    } ser_state_e;

    // Payload width: the wider of the {addr,id,rw} and {last,data} packets.
    function automatic int bsg_nasti_ser_pkt_width(input int addr_w, input int id_w, input int data_w);
        return (addr_w + id_w + 1 > data_w + 1) ? addr_w + id_w + 1 : data_w + 1;
    endfunction

endpackage

// File: rtl/bsg_nasti_req_arb.sv
// Two-input read/write arbiter: round-robin, write priority or read priority.
// A grant is a completed handshake, because each requester's ready is its grant.
module bsg_nasti_req_arb
    import bsg_nasti_req_serializer_pkg::*;
#(
    parameter int arb_mode_p = 0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic rd_v_i,
    input  logic wr_v_i,
    output logic rd_grant_o,
    output logic wr_grant_o
);

    grant_e last_grant_r;
    logic   pick_wr;

    always_comb begin
        // NOTE: default first so every path assigns pick_wr and no latch is inferred.
        pick_wr = wr_v_i;
        if (rd_v_i && wr_v_i) begin
            case (arb_mode_p)
                ARB_WRITE_PRIO: pick_wr = 1'b1;
                ARB_READ_PRIO:  pick_wr = 1'b0;
                default:        pick_wr = (last_grant_r == GRANT_READ);
            endcase
        end
    end

    assign rd_grant_o = en_i & rd_v_i & ~pick_wr;
    assign wr_grant_o = en_i & wr_v_i &  pick_wr;

    // Reset to "write granted last" so the first tie goes to the read side.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_grant_r <= GRANT_WRITE;
        end else if (rd_grant_o) begin
            last_grant_r <= GRANT_READ;
        end else if (wr_grant_o) begin
            last_grant_r <= GRANT_WRITE;
        end
    end

endmodule

// File: rtl/bsg_nasti_req_serializer.sv
// Serializes NASTI AR/AW/W requests into one tagged valid/ready packet stream.
// Address packets carry {addr,id,rw}; write-data packets carry {last,data} with a counter-derived last.
module bsg_nasti_req_serializer
    import bsg_nasti_req_serializer_pkg::*;
#(
    parameter  int addr_width_p = 32,
    parameter  int id_width_p   = 6,
    parameter  int data_width_p = 64,
    parameter  int len_width_p  = 8,
    parameter  int arb_mode_p   = 0,
    localparam int pkt_width_lp = bsg_nasti_ser_pkt_width(addr_width_p, id_width_p, data_width_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,

    input  logic                    ar_v_i,
    output logic                    ar_ready_o,
    input  logic [addr_width_p-1:0] ar_addr_i,
    input  logic [id_width_p-1:0]   ar_id_i,

    input  logic                    aw_v_i,
    output logic                    aw_ready_o,
    input  logic [addr_width_p-1:0] aw_addr_i,
    input  logic [id_width_p-1:0]   aw_id_i,
    input  logic [len_width_p-1:0]  aw_len_i,

    input  logic                    w_v_i,
    output logic                    w_ready_o,
    input  logic [data_width_p-1:0] w_data_i,
    input  logic                    w_last_i,

    output logic                    out_v_o,
    input  logic                    out_ready_i,
    output logic [pkt_width_lp:0]   out_data_o,

    output logic                    err_o
);

    localparam int sa_width_lp = addr_width_p + id_width_p + 1;
    localparam int sw_width_lp = data_width_p + 1;

    typedef struct packed {
        logic [addr_width_p-1:0] addr;
        logic [id_width_p-1:0]   id;
        logic                    rw;
    } bsg_nasti_sa_pkt;

    typedef struct packed {
        logic                    last;
        logic [data_width_p-1:0] data;
    } bsg_nasti_sw_pkt;

    ser_state_e             state_r;
    logic [len_width_p-1:0] beat_cnt_r;
    logic                   out_v_r;
    logic [pkt_width_lp:0]  out_data_r;
    logic                   err_r;

    logic                   load_en;
    logic                   ar_grant;
    logic                   aw_grant;
    logic                   w_hs;
    logic                   beat_last;
    bsg_nasti_sa_pkt        sa_pkt;
    bsg_nasti_sw_pkt        sw_pkt;
    logic [pkt_width_lp:0]  next_data;

    // Reset is folded in because out_v_r is already clear while reset is held.
    assign load_en = (~out_v_r | out_ready_i) & ~reset_i;

    bsg_nasti_req_arb #(
        .arb_mode_p (arb_mode_p)
    ) u_arb (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .en_i       (load_en & (state_r == S_IDLE)),
        .rd_v_i     (ar_v_i),
        .wr_v_i     (aw_v_i),
        .rd_grant_o (ar_grant),
        .wr_grant_o (aw_grant)
    );

    assign ar_ready_o = ar_grant;
    assign aw_ready_o = aw_grant;
    assign w_ready_o  = load_en & (state_r == S_WDATA);
    assign w_hs       = w_ready_o & w_v_i;
    assign beat_last  = (beat_cnt_r == '0);

    always_comb begin
        sa_pkt.addr = aw_grant ? aw_addr_i : ar_addr_i;
        sa_pkt.id   = aw_grant ? aw_id_i   : ar_id_i;
        sa_pkt.rw   = aw_grant;
        sw_pkt.last = beat_last;
        sw_pkt.data = w_data_i;

        next_data = '0;
        if (w_hs) begin
            next_data[pkt_width_lp]      = BSG_NASTI_SER_DATA;
            next_data[sw_width_lp-1:0]   = sw_pkt;
        end else begin
            next_data[pkt_width_lp]      = BSG_NASTI_SER_ADDR;
            next_data[sa_width_lp-1:0]   = sa_pkt;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= S_IDLE;
            beat_cnt_r <= '0;
            out_v_r    <= 1'b0;
            out_data_r <= '0;
            err_r      <= 1'b0;
        end else begin
            if (load_en) begin
                out_v_r <= ar_grant | aw_grant | w_hs;
                if (ar_grant | aw_grant | w_hs) begin
                    out_data_r <= next_data;
                end
            end

            case (state_r)
                S_IDLE: begin
                    if (aw_grant) begin
                        beat_cnt_r <= aw_len_i;
                        state_r    <= S_WDATA;
                    end
                end
                S_WDATA: begin
                    if (w_hs) begin
                        if (w_last_i != beat_last) begin
                            err_r <= 1'b1;
                        end
                        // Counting down from len means all-ones gives 2^len_width_p beats.
                        if (beat_last) begin
                            state_r <= S_IDLE;
                        end else begin
                            beat_cnt_r <= beat_cnt_r - len_width_p'(1);
                        end
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign out_v_o    = out_v_r;
    assign out_data_o = out_data_r;
    assign err_o      = err_r;

endmodule

// File: tb/tb_bsg_nasti_req_serializer.sv
// Self-checking bench for bsg_nasti_req_serializer: directed steps plus a randomized
// scoreboard phase; a second write-priority instance shares the inputs for the tie test.
module tb_bsg_nasti_req_serializer;

    localparam int AW = 32;
    localparam int IW = 6;
    localparam int DW = 64;
    localparam int LW = 8;
    localparam int PW = (AW + IW + 1 > DW + 1) ? AW + IW + 1 : DW + 1;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          ar_v_i, ar_ready_o;
    logic [AW-1:0] ar_addr_i;
    logic [IW-1:0] ar_id_i;
    logic          aw_v_i, aw_ready_o;
    logic [AW-1:0] aw_addr_i;
    logic [IW-1:0] aw_id_i;
    logic [LW-1:0] aw_len_i;
    logic          w_v_i, w_ready_o;
    logic [DW-1:0] w_data_i;
    logic          w_last_i;
    logic          out_v_o, out_ready_i;
    logic [PW:0]   out_data_o;
    logic          err_o;

    logic          wp_ar_ready, wp_aw_ready, wp_w_ready, wp_out_v, wp_err;
    logic [PW:0]   wp_out_data;

    logic          dir_ready, rnd_ready, rand_bp;
    assign out_ready_i = rand_bp ? rnd_ready : dir_ready;

    int            checks = 0;
    int            errors = 0;
    logic [PW:0]   exp_q[$];
    bit            mon_en = 1'b0;

    always #5 clk_i = ~clk_i;

    bsg_nasti_req_serializer #(
        .addr_width_p(AW), .id_width_p(IW), .data_width_p(DW), .len_width_p(LW), .arb_mode_p(0)
    ) u_dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .ar_v_i(ar_v_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i), .ar_id_i(ar_id_i),
        .aw_v_i(aw_v_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i), .aw_id_i(aw_id_i),
        .aw_len_i(aw_len_i),
        .w_v_i(w_v_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_last_i(w_last_i),
        .out_v_o(out_v_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o), .err_o(err_o)
    );

    bsg_nasti_req_serializer #(
        .addr_width_p(AW), .id_width_p(IW), .data_width_p(DW), .len_width_p(LW), .arb_mode_p(1)
    ) u_dut_wp (
        .clk_i(clk_i), .reset_i(reset_i),
        .ar_v_i(ar_v_i), .ar_ready_o(wp_ar_ready), .ar_addr_i(ar_addr_i), .ar_id_i(ar_id_i),
        .aw_v_i(aw_v_i), .aw_ready_o(wp_aw_ready), .aw_addr_i(aw_addr_i), .aw_id_i(aw_id_i),
        .aw_len_i(aw_len_i),
        .w_v_i(w_v_i), .w_ready_o(wp_w_ready), .w_data_i(w_data_i), .w_last_i(w_last_i),
        .out_v_o(wp_out_v), .out_ready_i(out_ready_i), .out_data_o(wp_out_data), .err_o(wp_err)
    );

    function automatic logic [PW:0] addr_pkt(input logic [AW-1:0] a, input logic [IW-1:0] id,
                                             input logic rw);
        logic [PW:0] p;
        p = '0;
        p[AW+IW:0] = {a, id, rw};
        return p;
    endfunction

    function automatic logic [PW:0] data_pkt(input logic last, input logic [DW-1:0] d);
        logic [PW:0] p;
        p = '0;
        p[PW] = 1'b1;
        p[DW:0] = {last, d};
        return p;
    endfunction

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic wait_ready(input int which, input string nm);
        logic rdy;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_i);
            case (which)
                0:       rdy = ar_ready_o;
                1:       rdy = aw_ready_o;
                default: rdy = w_ready_o;
            endcase
            if (rdy) begin
                step();
                return;
            end
            step();
        end
        checks++;
        errors++;
        $error("FAIL %s: no ready within 200 cycles", nm);
    endtask

    task automatic send_ar(input logic [AW-1:0] a, input logic [IW-1:0] id);
        ar_addr_i = a;
        ar_id_i   = id;
        ar_v_i    = 1'b1;
        wait_ready(0, "ar_handshake");
        ar_v_i    = 1'b0;
    endtask

    task automatic send_aw(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [LW-1:0] len);
        aw_addr_i = a;
        aw_id_i   = id;
        aw_len_i  = len;
        aw_v_i    = 1'b1;
        wait_ready(1, "aw_handshake");
        aw_v_i    = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic last);
        w_data_i = d;
        w_last_i = last;
        w_v_i    = 1'b1;
        wait_ready(2, "w_handshake");
        w_v_i    = 1'b0;
    endtask

    // Scoreboard: every accepted output packet must be the next one the bench expects.
    always @(negedge clk_i) begin
        if (mon_en && out_v_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_extra: observed=%0h expected=none", out_data_o);
            end else begin
                check("sb_pkt", out_data_o, exp_q.pop_front());
            end
        end
    end

    always @(posedge clk_i) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #400000;
        $error("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          last_w, in_w, in_w2;
        logic [PW:0] exp_prev;
        logic [2:0]  exp_rdy, exp_wp;

        reset_i = 1'b1;
        dir_ready = 1'b1; rnd_ready = 1'b1; rand_bp = 1'b0;
        ar_v_i = 1'b1; ar_addr_i = '0; ar_id_i = '0;
        aw_v_i = 1'b1; aw_addr_i = '0; aw_id_i = '0; aw_len_i = '0;
        w_v_i = 1'b1; w_data_i = '0; w_last_i = 1'b0;

        // Reset state, with every valid asserted
        sample();
        check("rst_out_v", out_v_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_err", err_o, 0);
        check("rst_readies", {ar_ready_o, aw_ready_o, w_ready_o}, 3'b000);
        step();
        reset_i = 1'b0;
        ar_v_i = 1'b0; aw_v_i = 1'b0; w_v_i = 1'b0;

        // Single read address
        ar_addr_i = 32'h1000; ar_id_i = 6'd5; ar_v_i = 1'b1;
        sample();
        check("t1_readies", {ar_ready_o, aw_ready_o, w_ready_o}, 3'b100);
        check("t1_out_v_before", out_v_o, 0);
        step();
        ar_v_i = 1'b0;
        sample();
        check("t1_pkt", {out_v_o, out_data_o}, {1'b1, addr_pkt(32'h1000, 6'd5, 1'b0)});
        check("t1_ar_ready_drop", ar_ready_o, 0);
        step();
        sample();
        check("t1_out_v_after", out_v_o, 0);
        step();

        // Write, len 3, four beats back to back
        aw_addr_i = 32'h2000; aw_id_i = 6'd3; aw_len_i = 8'd3; aw_v_i = 1'b1;
        w_v_i = 1'b1; w_data_i = 64'hA; w_last_i = 1'b0;
        sample();
        check("t2_readies", {ar_ready_o, aw_ready_o, w_ready_o}, 3'b010);
        step();
        aw_v_i = 1'b0;
        exp_prev = addr_pkt(32'h2000, 6'd3, 1'b1);
        for (int b = 0; b < 4; b++) begin
            sample();
            check($sformatf("t2_pkt%0d", b), {out_v_o, out_data_o}, {1'b1, exp_prev});
            check($sformatf("t2_wready%0d", b), w_ready_o, 1);
            step();
            exp_prev = data_pkt(b == 3, 64'hA + 64'(b));
            w_data_i = 64'hB + 64'(b);
            w_last_i = (b + 1 == 3);
        end
        w_v_i = 1'b0;
        sample();
        check("t2_pkt_last", {out_v_o, out_data_o}, {1'b1, exp_prev});
        check("t2_err", err_o, 0);
        check("t2_idle_wready", w_ready_o, 0);
        step();

        // Wrong w_last on the first of two beats
        aw_addr_i = 32'h3000; aw_id_i = 6'd7; aw_len_i = 8'd1; aw_v_i = 1'b1;
        w_v_i = 1'b1; w_data_i = 64'h55; w_last_i = 1'b1;
        sample();
        check("t4_readies", {ar_ready_o, aw_ready_o, w_ready_o}, 3'b010);
        step();
        aw_v_i = 1'b0;
        sample();
        check("t4_addr_pkt", {out_v_o, out_data_o}, {1'b1, addr_pkt(32'h3000, 6'd7, 1'b1)});
        check("t4_err_before", err_o, 0);
        step();
        w_data_i = 64'h66;
        sample();
        check("t4_beat0", {out_v_o, out_data_o}, {1'b1, data_pkt(1'b0, 64'h55)});
        check("t4_err_set", err_o, 1);
        check("t4_wready", w_ready_o, 1);
        step();
        sample();
        check("t4_beat1", {out_v_o, out_data_o}, {1'b1, data_pkt(1'b1, 64'h66)});
        check("t4_err_sticky", err_o, 1);
        check("t4_back_idle", w_ready_o, 0);
        step();
        w_v_i = 1'b0; w_last_i = 1'b0;

        // Back-pressure mid-burst
        aw_addr_i = 32'h4000; aw_id_i = 6'd2; aw_len_i = 8'd3; aw_v_i = 1'b1;
        w_v_i = 1'b1; w_data_i = 64'h11; w_last_i = 1'b0;
        sample();
        step();
        aw_v_i = 1'b0;
        sample();
        check("t5_addr_pkt", {out_v_o, out_data_o}, {1'b1, addr_pkt(32'h4000, 6'd2, 1'b1)});
        step();
        dir_ready = 1'b0;
        w_data_i = 64'h12;
        for (int i = 0; i < 5; i++) begin
            sample();
            check($sformatf("t5_hold%0d", i), {out_v_o, out_data_o}, {1'b1, data_pkt(1'b0, 64'h11)});
            check($sformatf("t5_wready%0d", i), w_ready_o, 0);
            step();
        end
        dir_ready = 1'b1;
        for (int b = 1; b < 4; b++) begin
            sample();
            check($sformatf("t5_resume%0d", b), {out_v_o, out_data_o},
                  {1'b1, data_pkt(1'b0, 64'h10 + 64'(b))});
            check($sformatf("t5_resume_wready%0d", b), w_ready_o, 1);
            step();
            w_data_i = 64'h12 + 64'(b);
            w_last_i = (b + 1 == 3);
        end
        w_v_i = 1'b0;
        sample();
        check("t5_final", {out_v_o, out_data_o}, {1'b1, data_pkt(1'b1, 64'h14)});
        check("t5_err_still", err_o, 1);
        step();
        w_last_i = 1'b0;

        // Randomized transactions under random back-pressure
        exp_q.delete();
        mon_en = 1'b1;
        rand_bp = 1'b1;
        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] a;
            logic [IW-1:0] id;
            logic [LW-1:0] len;
            a  = $urandom;
            id = IW'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) begin
                exp_q.push_back(addr_pkt(a, id, 1'b0));
                send_ar(a, id);
            end else begin
                len = LW'($urandom_range(0, 4));
                exp_q.push_back(addr_pkt(a, id, 1'b1));
                send_aw(a, id, len);
                for (int b = 0; b <= int'(len); b++) begin
                    logic [DW-1:0] d;
                    d = {$urandom, $urandom};
                    exp_q.push_back(data_pkt(b == int'(len), d));
                    send_w(d, b == int'(len));
                end
            end
        end
        for (int n = 0; n < 100; n++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check("sb_drained", exp_q.size(), 0);
        mon_en = 1'b0;
        rand_bp = 1'b0;
        step();
        check("rand_err_sticky", err_o, 1);

        // Reset in the middle of an 8-beat burst
        aw_addr_i = 32'h5000; aw_id_i = 6'd1; aw_len_i = 8'd7; aw_v_i = 1'b1;
        w_v_i = 1'b1; w_data_i = 64'h70; w_last_i = 1'b0;
        sample();
        step();
        aw_v_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            sample();
            step();
            w_data_i = 64'h71 + 64'(b);
        end
        reset_i = 1'b1;
        #1;
        check("t6_out_v", out_v_o, 0);
        check("t6_err", err_o, 0);
        check("t6_readies", {ar_ready_o, aw_ready_o, w_ready_o}, 3'b000);
        step();
        reset_i = 1'b0;
        w_v_i = 1'b0;
        ar_addr_i = 32'h6000; ar_id_i = 6'd9; ar_v_i = 1'b1;
        sample();
        check("t6_ar_readies", {ar_ready_o, aw_ready_o, w_ready_o}, 3'b100);
        step();
        ar_v_i = 1'b0;
        sample();
        check("t6_ar_pkt", {out_v_o, out_data_o}, {1'b1, addr_pkt(32'h6000, 6'd9, 1'b0)});
        step();

        // Read and write both pending every cycle
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        ar_addr_i = 32'h7000; ar_id_i = 6'd4; ar_v_i = 1'b1;
        aw_addr_i = 32'h8000; aw_id_i = 6'd6; aw_len_i = 8'd0; aw_v_i = 1'b1;
        w_data_i = 64'hBEEF; w_last_i = 1'b1; w_v_i = 1'b1;
        last_w = 1'b1; in_w = 1'b0; in_w2 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (in_w)        begin exp_rdy = 3'b001; in_w = 1'b0; end
            else if (last_w) begin exp_rdy = 3'b100; last_w = 1'b0; end
            else             begin exp_rdy = 3'b010; last_w = 1'b1; in_w = 1'b1; end
            if (in_w2) begin exp_wp = 3'b001; in_w2 = 1'b0; end
            else       begin exp_wp = 3'b010; in_w2 = 1'b1; end
            sample();
            check($sformatf("rr_grant%0d", c), {ar_ready_o, aw_ready_o, w_ready_o}, exp_rdy);
            check($sformatf("wp_grant%0d", c), {wp_ar_ready, wp_aw_ready, wp_w_ready}, exp_wp);
            step();
        end
        ar_v_i = 1'b0; aw_v_i = 1'b0; w_v_i = 1'b0;
        sample();
        check("rr_last_pkt", {out_v_o, out_data_o}, {1'b1, data_pkt(1'b1, 64'hBEEF)});
        check("wp_last_pkt", {wp_out_v, wp_out_data}, {1'b1, data_pkt(1'b1, 64'hBEEF)});
        check("wp_err", wp_err, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bsg_nasti_req_serializer.md
Name: bsg_nasti_req_serializer

Overview:
- Merges the NASTI AR, AW and W request channels into one tagged, valid/ready serial stream of address packets ({addr,id,rw}) and write-data packets ({last,data}) for transport over the FSB tunnel.
- Generalises the fixed 32/6/64-bit request packet formats to parametrised widths.
- Adds read/write arbitration, burst-length tracking from AW.len, and a sticky W.last protocol-error flag.
- Sits on the chip side between the rocket NASTI master port and the tunnel demux input.

Parameters:
addr_width_p, 32, NASTI address width
id_width_p, 6, NASTI transaction id width
data_width_p, 64, NASTI data beat width
len_width_p, 8, AW.len width (beats-1)
arb_mode_p, 0, 0 = round-robin read/write, 1 = write priority, 2 = read priority

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
ar_v_i  in  1  read address valid
ar_ready_o  out  1  read address ready
ar_addr_i  in  addr_width_p  read address
ar_id_i  in  id_width_p  read id
aw_v_i  in  1  write address valid
aw_ready_o  out  1  write address ready
aw_addr_i  in  addr_width_p  write address
aw_id_i  in  id_width_p  write id
aw_len_i  in  len_width_p  burst beats minus one
w_v_i  in  1  write data valid
w_ready_o  out  1  write data ready
w_data_i  in  data_width_p  write data
w_last_i  in  1  master's last-beat flag
out_v_o  out  1  serial packet valid
out_ready_i  in  1  serial packet ready
out_data_o  out  1+pkt_width_lp  {tag, payload}; tag 0 = address, 1 = write data; pkt_width_lp = max(addr_width_p+id_width_p+1, data_width_p+1); payload zero-padded in MSBs
err_o  out  1  sticky: W.last disagreed with the beat count

Behaviour:
- One-entry output register (out_v_r, out_data_r).
  - load_en = !out_v_r | out_ready_i.
  - Every input ready is gated by load_en.
  - Latency is one cycle from input handshake to out_v_o.
  - Full throughput: one packet per cycle while out_ready_i is held high.
- FSM, IDLE:
  - W is never accepted: w_ready_o = 0.
  - Arbitrate ar_v_i vs aw_v_i per arb_mode_p.
  - Round-robin: last_grant_r toggles only on a granted handshake; reset value is "write granted last", so read wins the first tie.
  - Read grant: emit tag 0, {ar_addr, ar_id, rw=0}; stay in IDLE.
  - Write grant: emit tag 0, {aw_addr, aw_id, rw=1}; load beat_cnt_r = aw_len_i; go to WDATA.
  - Only one of ar_ready_o and aw_ready_o is high in any cycle.
- FSM, WDATA:
  - ar_ready_o = aw_ready_o = 0; w_ready_o = load_en.
  - Each W handshake emits tag 1, {last = (beat_cnt_r == 0), w_data_i}, then decrements beat_cnt_r.
  - The counter-derived last is authoritative and is the value sent.
  - If w_last_i != (beat_cnt_r == 0) on a handshake, set err_o.
  - The handshake with beat_cnt_r == 0 returns the FSM to IDLE.
  - AW.len = 0 yields exactly one data beat.
  - AW.len = all-ones yields 2^len_width_p beats; the counter must not wrap early.
- Output back-pressure: when out_ready_i = 0 with the register full, all input readies are 0 and the register holds its value.
- Reset, asynchronous:
  - out_v_o = 0, out_data_o = 0, err_o = 0.
  - All readies = 0 while reset is asserted.
  - FSM = IDLE, beat_cnt_r = 0, last_grant_r = write.
  - Reset mid-burst abandons the burst; no partial-burst recovery.
- err_o clears only on reset.
- Inputs are not held if not granted; masters must keep valid asserted per NASTI rules.

Decomposition:
- Shared package gets parametrised equivalents of the request packet types:
  - bsg_nasti_sa_pkt (addr, id, rw) and bsg_nasti_sw_pkt (last, data), sized by the parameters.
  - A tag localparam pair (BSG_NASTI_SER_ADDR = 0, BSG_NASTI_SER_DATA = 1).
  - A width function for pkt_width_lp.
- One natural sub-module: bsg_nasti_req_arb, the 2-input arbiter implementing arb_mode_p with round-robin state.
- FSM, counter and output register stay in the top module.

Test Plan:
- AR only (addr 0x1000, id 5), out_ready_i = 1 -> next cycle tag 0, payload {0x1000, 5, rw=0}, ar_ready_o high exactly one cycle.
- AW (addr 0x2000, id 3, len 3) plus 4 W beats 0xA..0xD with last on beat 4 -> 5 consecutive packets: the address packet, then data beats with last flags 0,0,0,1; err_o stays 0.
- AR and AW both valid every cycle, arb_mode_p = 0 -> grants alternate read, write(len 0 + 1 beat), read, ...; with arb_mode_p = 1 the write always wins.
- W burst with len 1 and w_last_i = 1 on beat 1 -> emitted last flags 0,1; err_o rises on beat 1 and stays high; FSM returns to IDLE after beat 2.
- out_ready_i held 0 for 5 cycles mid-burst -> out_data_o stable, w_ready_o = 0; on release, beats resume with none lost or duplicated.
- Assert reset_i mid-burst (len 7, after 3 beats) -> out_v_o = 0 and err_o = 0 immediately; after release the FSM is in IDLE and a new AR is served normally.
